// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter
//   Shares one pipelined integer square-root core between N requesters.
//   Round-robin arbitration with valid/ready per requester, at most one
//   operand issued per cycle, a tag line matched to the core latency that
//   routes each root/remainder back with its requester ID, an outstanding
//   operation counter (busy) and a sticky alignment error flag (err).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_data  per-requester operand handshake (inputs)
//   req_ready           one-hot grant, combinational
//   sq_valid/sq_data    registered operand to the core
//   sq_o_valid/sq_q/sq_r core result inputs
//   res_valid/res_id/res_q/res_r  registered result strobe and payload
//   busy                operations accepted but not yet returned
//   err                 sticky: core output did not match an issued tag
module sqrt_arbiter #(
  parameter int N       = 4,
  parameter int D_WIDTH = 58,
  parameter int LAT     = D_WIDTH / 2 + 1,
  parameter int ID_W    = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  input  logic [N*D_WIDTH-1:0]   req_data,
  output logic [N-1:0]           req_ready,
  output logic                   sq_valid,
  output logic [D_WIDTH-1:0]     sq_data,
  input  logic                   sq_o_valid,
  input  logic [D_WIDTH/2-1:0]   sq_q,
  input  logic [D_WIDTH/2:0]     sq_r,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [D_WIDTH/2-1:0]   res_q,
  output logic [D_WIDTH/2:0]     res_r,
  output logic                   busy,
  output logic                   err
);

  localparam int QW = D_WIDTH / 2;
  localparam int RW = D_WIDTH / 2 + 1;
  localparam int CW = $clog2(LAT + 3);

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] grant_id;
  logic            transfer;

  // Round-robin search starting at ptr_reg; first valid requester wins.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    transfer  = 1'b0;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (!transfer && req_valid[(int'(ptr_reg) + i) % N]) begin
          transfer  = 1'b1;
          grant_id  = ID_W'((int'(ptr_reg) + i) % N);
          req_ready[(int'(ptr_reg) + i) % N] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (transfer) begin
      ptr_reg <= (int'(grant_id) == N - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Issue stage: operand to the core plus the first tag stage.
  logic [ID_W-1:0] issue_id_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_valid     <= 1'b0;
      sq_data      <= '0;
      issue_id_reg <= '0;
    end else begin
      sq_valid     <= transfer;
      sq_data      <= transfer ? req_data[int'(grant_id)*D_WIDTH +: D_WIDTH] : '0;
      issue_id_reg <= transfer ? grant_id : '0;
    end
  end

  // The tag line samples the issue stage on the same edge the core samples
  // i_vaild, so after LAT more stages its tail coincides with core o_vaild.
  logic            tag_v_reg  [LAT];
  logic [ID_W-1:0] tag_id_reg [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_reg[0]  <= 1'b0;
      tag_id_reg[0] <= '0;
    end else begin
      tag_v_reg[0]  <= sq_valid;
      tag_id_reg[0] <= issue_id_reg;
    end
  end

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_v_reg[gi]  <= 1'b0;
          tag_id_reg[gi] <= '0;
        end else begin
          tag_v_reg[gi]  <= tag_v_reg[gi-1];
          tag_id_reg[gi] <= tag_id_reg[gi-1];
        end
      end
    end
  endgenerate

  logic            tag_v_last;
  logic [ID_W-1:0] tag_id_last;
  logic            hit;

  assign tag_v_last  = tag_v_reg[LAT-1];
  assign tag_id_last = tag_id_reg[LAT-1];
  assign hit         = sq_o_valid & tag_v_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_q     <= '0;
      res_r     <= '0;
      err       <= 1'b0;
    end else begin
      res_valid <= hit;
      res_id    <= hit ? tag_id_last : '0;
      res_q     <= hit ? sq_q : QW'(0);
      res_r     <= hit ? sq_r : RW'(0);
      if (sq_o_valid != tag_v_last) begin
        err <= 1'b1;
      end
    end
  end

  // Outstanding operations: accepted transfers minus delivered results.
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (transfer && !res_valid) begin
      count_reg <= count_reg + CW'(1);
    end else if (!transfer && res_valid) begin
      // Only reachable at zero on an error path; clamp instead of wrapping.
      count_reg <= (count_reg == '0) ? '0 : count_reg - CW'(1);
    end
  end

  assign busy = (count_reg != '0);

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Shares one pipelined integer square-root unit between N requesters in the FFT magnitude path, e.g. the per-channel |X|² producers. It uses round-robin arbitration with a valid/ready handshake on each requester and feeds at most one operand per cycle into the sqrt core. A tag delay line matched to the core latency routes each root and remainder back with its requester ID. The block also tracks outstanding operations and flags any core output that does not line up with an issued operand.

## Interface
- N, 4, number of requesters (2..8)
- D_WIDTH, 58, operand width (even); core root width D_WIDTH/2, remainder width D_WIDTH/2+1
- LAT, D_WIDTH/2+1 (=30), core latency: core o_vaild LAT cycles after it samples i_vaild
- ID_W, clog2(N) (=2), requester ID width
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset; the same signal also resets the sqrt core
- req_valid  in  N  operand valid, one bit per requester
- req_data  in  N*D_WIDTH  operands; requester k occupies bits [k*D_WIDTH +: D_WIDTH]
- req_ready  out  N  one-hot grant, combinational from req_valid and the RR pointer
- sq_valid  out  1  to core i_vaild, registered
- sq_data  out  D_WIDTH  to core data_i, registered
- sq_o_valid  in  1  from core o_vaild
- sq_q  in  D_WIDTH/2  from core data_o
- sq_r  in  D_WIDTH/2+1  from core data_r
- res_valid  out  1  result strobe, registered; no backpressure
- res_id  out  ID_W  requester that owns the result
- res_q  out  D_WIDTH/2  root
- res_r  out  D_WIDTH/2+1  remainder
- busy  out  1  high while any operation is accepted but not yet returned
- err  out  1  sticky alignment error

## Operation
- Arbitration:
  - Round-robin pointer ptr, reset value 0.
  - Search order is ptr, ptr+1, … mod N.
  - The first requester in that order with req_valid=1 gets its req_ready bit; all other req_ready bits are 0.
  - At most one grant per cycle.
- Transfer occurs when req_valid[k]&req_ready[k]. On a transfer, ptr <= (k+1) mod N. With no transfer, ptr holds.
- Issue: on the cycle after a transfer, sq_valid=1, sq_data=req_data[k], and tag stage 0 = {1, k}. Otherwise sq_valid=0, sq_data=0, and stage 0 = {0, 0}.
- Tag line:
  - LAT-stage shift register of {v, id}, advancing every cycle.
  - The last stage aligns with sq_o_valid.
- Return:
  - res_valid <= sq_o_valid & tag_v_last.
  - res_id <= tag_id_last.
  - res_q <= sq_q and res_r <= sq_r when the result is valid; otherwise all three are 0.
- Error: err <= 1 when sq_o_valid != tag_v_last. It is cleared only by rst. On a mismatch no res_valid is produced.
- Outstanding counter:
  - Width clog2(LAT+3).
  - +1 on a transfer, −1 on res_valid; a simultaneous increment and decrement leaves it unchanged.
  - busy = (count != 0).
  - The counter never exceeds LAT+2 and cannot underflow. An error path that would underflow holds the count at 0.
- Fairness: with all N requesters continuously valid, each is granted exactly once every N cycles.
- Throughput: one operand per cycle sustained; the core is fully pipelined, so no stall is needed.

## Timing
- Reset values: req_ready = 0, sq_valid = 0, sq_data = 0, res_valid = 0, res_id = 0, res_q = 0, res_r = 0, busy = 0, err = 0, ptr = 0, all tag stages cleared.
- req_ready is held at 0 while rst=1.
- Latency: a handshake in cycle t gives sq_valid in t+1, core output in t+1+LAT, and res_valid in t+2+LAT (=t+32 at the defaults).
- Results return in issue order; there is one result per accepted operand.
- Reset mid-operation: all in-flight operations are discarded. No res_valid appears after rst deasserts until a new transfer has had LAT+2 cycles to complete. err stays 0.
- Requesters may drop req_valid without a transfer. Data is sampled only on the transfer cycle.

## Test plan
- Single operand: requester 2 sends 16 at t → res_valid at t+32 with id=2, q=4, r=0. busy is high from t+1 through t+32 and falls at t+33.
- Remainder and extremes:
  - 17 → q=4, r=1.
  - 0 → q=0, r=0.
  - 2^58−1 → q=536870911, r=1073741822.
- Round-robin: all 4 requesters held valid from reset with operands 4·(k+1)² → grants 0,1,2,3,0,… one per cycle. Results return back-to-back, ids in the same order, q=2(k+1).
- Pointer rotation: only requesters 1 and 3 valid, ptr=2 → 3 is granted first, then 1, then 3. A requester that drops req_valid is skipped with no gap cycle.
- Reset mid-flight: issue 10 operands, assert rst for 1 cycle at the 5th issue → no res_valid for any pre-reset operand. busy=0 and err=0 after reset. A new operand 81 returns q=9, r=0 with the normal latency.
- Misalignment: force a spurious sq_o_valid pulse with no issued tag → err rises the next cycle and stays high, with no res_valid. An inverse test, a swallowed o_vaild, also sets err.
